// File: rtl/microsequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : microsequencer_pkg
//  Description : Shared definitions for the microcode sequencer. Holds the
//                sequencer state encodings and the default field widths that
//                the top level and its benches agree on.
//  Revision    : 1.0  initial release
// ============================================================================
package microsequencer_pkg;

    // Default field widths and wait bound
    localparam int OPCODE_BITS_DEF = 8;
    localparam int T_BITS_DEF      = 3;
    localparam int WAIT_LIMIT_DEF  = 255;

    // Sequencer state encodings
    typedef logic [1:0] state_t;
    localparam state_t S_RUN  = 2'd0;
    localparam state_t S_WAIT = 2'd1;
    localparam state_t S_HALT = 2'd2;
    localparam state_t S_STEP = 2'd3;

endpackage : microsequencer_pkg
`default_nettype wire

// File: rtl/microsequencer_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module      : microsequencer_wait_timer
//  Description : 8-bit saturating wait-cycle counter. A load starts a new wait
//                at a count of 1, clear returns it to 0, inc counts one more
//                wait cycle. o_hit flags that the count reached LIMIT.
//  Ports       : clk, rst_n (async active-low), i_load, i_clear, i_inc,
//                o_hit
//  Revision    : 1.0  initial release
// ============================================================================
module microsequencer_wait_timer #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_hit
);

    localparam logic [7:0] c_limit = 8'(LIMIT);

    logic [7:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 8'd0;
        end else if (i_load) begin
            r_count <= 8'd1;
        end else if (i_clear) begin
            r_count <= 8'd0;
        end else if (i_inc && (r_count != 8'hFF)) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign o_hit = (r_count >= c_limit);

endmodule : microsequencer_wait_timer
`default_nettype wire

// File: rtl/microsequencer.sv
`default_nettype none
// ============================================================================
//  Module      : microsequencer
//  Description : Microcode sequencer. Forms the ROM address {opcode, T},
//                advances the T-state counter, and adds halt/single-step and
//                device wait states. A single clk_en stalls the datapath.
//  Ports       : clk, reset_bar (async active-low)
//                opcode, rt, dev_access, dev_ready, halt_req, step  (inputs)
//                uaddr, tstate, clk_en, halted, waiting, wait_tmo   (outputs)
//  Revision    : 1.0  initial release
// ============================================================================
module microsequencer
    import microsequencer_pkg::*;
#(
    parameter int OPCODE_BITS = OPCODE_BITS_DEF,
    parameter int T_BITS      = T_BITS_DEF,
    parameter int WAIT_LIMIT  = WAIT_LIMIT_DEF
) (
    input  logic                      clk,
    input  logic                      reset_bar,
    input  logic [OPCODE_BITS-1:0]    opcode,
    input  logic                      rt,
    input  logic                      dev_access,
    input  logic                      dev_ready,
    input  logic                      halt_req,
    input  logic                      step,
    output logic [OPCODE_BITS+T_BITS-1:0] uaddr,
    output logic [T_BITS-1:0]         tstate,
    output logic                      clk_en,
    output logic                      halted,
    output logic                      waiting,
    output logic                      wait_tmo
);

    state_t              r_state;
    state_t              w_state_nxt;
    state_t              r_origin;      // RUN or STEP: where a WAIT returns to
    logic [T_BITS-1:0]   r_tstate;
    logic                r_step_meta;
    logic                r_step_sync;
    logic                r_step_prev;
    logic                r_wait_tmo;

    logic                w_active;
    logic                w_stall;
    logic                w_hit;
    logic                w_release;
    logic                w_commit;
    logic                w_timeout;
    logic                w_step_edge;
    logic [T_BITS-1:0]   w_t_nxt;
    logic                w_boundary;

    assign w_active    = (r_state == S_RUN) || (r_state == S_STEP);
    assign w_stall     = w_active && dev_access && !dev_ready;
    // A wait ends on ready, or is forced through once the bound is reached
    assign w_release   = (r_state == S_WAIT) && (dev_ready || w_hit);
    assign w_timeout   = (r_state == S_WAIT) && !dev_ready && w_hit;
    assign w_commit    = (w_active && !w_stall) || w_release;
    assign w_t_nxt     = rt ? '0 : r_tstate + T_BITS'(1);
    // Any commit that lands on T=0 (rt or natural wrap) is an instruction boundary
    assign w_boundary  = (w_t_nxt == '0);
    assign w_step_edge = r_step_sync && !r_step_prev;

    microsequencer_wait_timer #(
        .LIMIT (WAIT_LIMIT)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (reset_bar),
        .i_load  (w_stall),
        .i_clear (w_release),
        .i_inc   ((r_state == S_WAIT) && !w_release),
        .o_hit   (w_hit)
    );

    // State register
    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; STEP behaves as RUN except that it is entered from HALT
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN, S_STEP: begin
                if (w_stall) begin
                    w_state_nxt = S_WAIT;
                end else if (w_boundary) begin
                    w_state_nxt = halt_req ? S_HALT : S_RUN;
                end
            end
            S_WAIT: begin
                if (w_release) begin
                    if (w_boundary) begin
                        w_state_nxt = halt_req ? S_HALT : S_RUN;
                    end else begin
                        w_state_nxt = r_origin;
                    end
                end
            end
            S_HALT: begin
                if (w_step_edge) begin
                    w_state_nxt = S_STEP;
                end else if (!halt_req) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: w_state_nxt = S_RUN;
        endcase
    end

    // Output decode; clk_en is forced low while reset is held
    always_comb begin
        clk_en  = reset_bar && w_commit;
        halted  = (r_state == S_HALT);
        waiting = (r_state == S_WAIT);
    end

    // T-state counter, origin memory and sticky timeout flag
    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            r_tstate   <= '0;
            r_origin   <= S_RUN;
            r_wait_tmo <= 1'b0;
        end else begin
            if (w_commit) begin
                r_tstate <= w_t_nxt;
            end
            if (w_stall) begin
                r_origin <= r_state;
            end
            if (w_timeout) begin
                r_wait_tmo <= 1'b1;
            end
        end
    end

    // Step button: two-flop synchroniser followed by rising-edge detect
    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            r_step_meta <= 1'b0;
            r_step_sync <= 1'b0;
            r_step_prev <= 1'b0;
        end else begin
            r_step_meta <= step;
            r_step_sync <= r_step_meta;
            r_step_prev <= r_step_sync;
        end
    end

    assign uaddr    = {opcode, r_tstate};
    assign tstate   = r_tstate;
    assign wait_tmo = r_wait_tmo;

endmodule : microsequencer
`default_nettype wire

// File: tb/tb_microsequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_microsequencer
//  Description : Self-checking bench for microsequencer. A behavioural model
//                predicts each cycle's outputs into a queue; a monitor pops
//                and compares on every falling clock edge.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_microsequencer;

    localparam int OB = 8;
    localparam int TB = 3;
    localparam int WL = 255;
    localparam int TN = 1 << TB;

    logic            clk = 1'b0;
    logic            reset_bar;
    logic [OB-1:0]   opcode;
    logic            rt, dev_access, dev_ready, halt_req, step;
    logic [OB+TB-1:0] uaddr;
    logic [TB-1:0]   tstate;
    logic            clk_en, halted, waiting, wait_tmo;

    microsequencer #(
        .OPCODE_BITS (OB),
        .T_BITS      (TB),
        .WAIT_LIMIT  (WL)
    ) dut (
        .clk        (clk),
        .reset_bar  (reset_bar),
        .opcode     (opcode),
        .rt         (rt),
        .dev_access (dev_access),
        .dev_ready  (dev_ready),
        .halt_req   (halt_req),
        .step       (step),
        .uaddr      (uaddr),
        .tstate     (tstate),
        .clk_en     (clk_en),
        .halted     (halted),
        .waiting    (waiting),
        .wait_tmo   (wait_tmo)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [OB+TB-1:0] ua;
        logic [TB-1:0]    t;
        logic             en;
        logic             hlt;
        logic             wt;
        logic             tmo;
    } obs_t;

    obs_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: instruction progress plus a few mode flags
    int         m_t;
    bit         m_halt, m_wait, m_tmo;
    int         m_wcnt;
    bit         s_d1, s_d2, s_d3;   // step levels of the last three cycles
    logic [OB-1:0] cur_op;

    function automatic obs_t sample();
        obs_t g;
        g.ua = uaddr; g.t = tstate; g.en = clk_en;
        g.hlt = halted; g.wt = waiting; g.tmo = wait_tmo;
        return g;
    endfunction

    task automatic compare(input string name, input obs_t g, input obs_t e);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s @%0t: got uaddr=%h t=%0d en=%b halted=%b waiting=%b tmo=%b, expected uaddr=%h t=%0d en=%b halted=%b waiting=%b tmo=%b",
                     name, $time, g.ua, g.t, g.en, g.hlt, g.wt, g.tmo,
                     e.ua, e.t, e.en, e.hlt, e.wt, e.tmo);
        end
    endtask

    // Monitor: one prediction per clock cycle
    initial begin : monitor
        obs_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                compare("cycle", sample(), e);
            end
        end
    end

    // Commit: move one microinstruction forward, halting at a boundary if asked
    task automatic advance(input bit i_rt, input bit i_hr);
        m_t = i_rt ? 0 : (m_t + 1) % TN;
        if (m_t == 0 && i_hr) m_halt = 1'b1;
    endtask

    // Called at posedge+1: drive one cycle of inputs, predict, wait for the edge
    task automatic cycle(input bit i_rt, input bit i_da, input bit i_dr,
                         input bit i_hr, input bit i_st);
        obs_t e;
        bit   edge_seen;
        opcode = cur_op; rt = i_rt; dev_access = i_da; dev_ready = i_dr;
        halt_req = i_hr; step = i_st;
        edge_seen = s_d2 && !s_d3;
        e.ua = {cur_op, TB'(m_t)}; e.t = TB'(m_t);
        e.hlt = m_halt; e.wt = m_wait; e.tmo = m_tmo;
        if (m_halt) begin
            e.en = 1'b0;
            if (edge_seen || !i_hr) m_halt = 1'b0;
        end else if (m_wait) begin
            if (i_dr || m_wcnt >= WL) begin
                e.en = 1'b1;
                if (!i_dr) m_tmo = 1'b1;
                m_wait = 1'b0;
                advance(i_rt, i_hr);
            end else begin
                e.en = 1'b0;
                m_wcnt++;
            end
        end else if (i_da && !i_dr) begin
            e.en = 1'b0; m_wait = 1'b1; m_wcnt = 1;
        end else begin
            e.en = 1'b1;
            advance(i_rt, i_hr);
        end
        q.push_back(e);
        s_d3 = s_d2; s_d2 = s_d1; s_d1 = i_st;
        @(posedge clk); #1;
    endtask

    // Called at posedge+1: asynchronous reset, checked immediately
    task automatic do_reset();
        obs_t e;
        reset_bar = 1'b0;
        #1;
        e.ua = {opcode, TB'(0)}; e.t = '0; e.en = 1'b0;
        e.hlt = 1'b0; e.wt = 1'b0; e.tmo = 1'b0;
        compare("async_reset", sample(), e);
        rt = 0; dev_access = 0; dev_ready = 1; halt_req = 0; step = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_bar = 1'b1;
        m_t = 0; m_halt = 0; m_wait = 0; m_tmo = 0; m_wcnt = 0;
        s_d1 = 0; s_d2 = 0; s_d3 = 0;
    endtask

    initial begin : stim
        bit hr_r, st_r;
        reset_bar = 1'b0; opcode = '0; rt = 0; dev_access = 0; dev_ready = 1;
        halt_req = 0; step = 0; cur_op = 8'h12;
        @(posedge clk); #1;
        do_reset();

        // rt at T=3: 090,091,092,093,090
        for (int i = 0; i < 5; i++) cycle(m_t == 3, 0, 1, 0, 0);
        // bring to T=0, then 9 cycles with no rt to see the wrap
        while (m_t != 0) cycle(1, 0, 1, 0, 0);
        for (int i = 0; i < 9; i++) cycle(0, 0, 1, 0, 0);

        // device wait at T=2 for 4 cycles, then ready
        while (m_t != 2) cycle(0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 1, 0, 0);
        while (m_t != 0) cycle(m_t == 5, 0, 1, 0, 0);

        // wait that never sees ready: forced continue after WAIT_LIMIT
        cycle(0, 0, 1, 0, 0);
        for (int i = 0; i < WL + 1; i++) cycle(0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0, 0);

        // halt request mid-instruction, then single-step with a held button
        while (m_t != 1) cycle(0, 0, 1, 0, 0);
        for (int i = 0; i < 20 && !m_halt; i++) cycle(m_t == 3, 0, 1, 1, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 1, 0);
        for (int i = 0; i < 8; i++) cycle(m_t == 2, 0, 1, 1, 1);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 1, 0);
        for (int i = 0; i < 3; i++) cycle(m_t == 2, 0, 1, 0, 0);

        // reset while waiting at T=4 (timeout flag still set from above)
        while (m_t != 4) cycle(0, 0, 1, 0, 0);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        do_reset();

        // randomized traffic
        hr_r = 0; st_r = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) hr_r = ~hr_r;
            if ($urandom_range(0, 7) == 0) st_r = ~st_r;
            if (m_t == 0 && !m_wait && $urandom_range(0, 1) == 1) cur_op = 8'($urandom);
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                      $urandom_range(0, 3) != 0, hr_r, st_r);
            end
        end

        @(negedge clk); #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d predictions left, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_microsequencer
`default_nettype wire
